// File: rtl/alu_4_cmd_ctrl.sv
// Command sequencer for a combinational 4-bit ALU: accept a command, give the ALU one cycle to settle,
// capture its result with flags, and hold the response until the consumer takes it.
module alu_4_cmd_ctrl #(
   parameter int CNT_W  = 8,
   parameter int OP_MAX = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [7:0]       alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_MAX_L = 4'(OP_MAX);

   state_t state;
   logic   op_illegal;
   logic   op_arith;

   // A response being drained in DONE frees the controller for a new command in the same cycle.
   assign cmd_ready  = !rst && ((state == IDLE) || ((state == DONE) && rsp_ready));
   assign op_illegal = (alu_ctrl > OP_MAX_L);
   assign op_arith   = (alu_ctrl == 4'd0) || (alu_ctrl == 4'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_ctrl  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  alu_a    <= cmd_a;
                  alu_b    <= cmd_b;
                  alu_ctrl <= cmd_op;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // Carry lives in bit 4 only for add/sub; illegal opcodes report a clean zero result.
               rsp_data  <= op_illegal ? 8'd0 : alu_y;
               rsp_zero  <= op_illegal || (alu_y == 8'd0);
               rsp_carry <= !op_illegal && op_arith && alu_y[4];
               rsp_err   <= op_illegal;
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  if (cmd_valid) begin
                     alu_a    <= cmd_a;
                     alu_b    <= cmd_b;
                     alu_ctrl <= cmd_op;
                     state    <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_4_cmd_ctrl.sv
// Bench for alu_4_cmd_ctrl with a behavioural alu_4 stand-in and a result model derived from opcode rules.
module tb_alu_4_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = '0, cmd_a = '0, cmd_b = '0;
   logic [3:0] alu_a, alu_b, alu_ctrl;
   logic [7:0] alu_y;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_zero, rsp_carry, rsp_err;
   logic [7:0] op_count;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;

   alu_4_cmd_ctrl #(.CNT_W(8), .OP_MAX(9)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .op_count(op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational alu_4 stand-in driven by the controller's registered outputs.
   always_comb begin
      alu_y = 8'd0;
      case (alu_ctrl)
         4'd0: alu_y = {3'b0, {1'b0, alu_a} + {1'b0, alu_b}};
         4'd1: alu_y = {3'b0, {1'b0, alu_a} - {1'b0, alu_b}};
         4'd2: alu_y = {4'b0, alu_a & alu_b};
         4'd3: alu_y = {4'b0, alu_a | alu_b};
         4'd4: alu_y = {4'b0, ~alu_a};
         4'd5: alu_y = {4'b0, ~(alu_a & alu_b)};
         4'd6: alu_y = {4'b0, ~(alu_a | alu_b)};
         4'd7: alu_y = {4'b0, alu_a ^ alu_b};
         4'd8: alu_y = {4'b0, ~(alu_a ^ alu_b)};
         4'd9: alu_y = {4'b0, alu_a} * {4'b0, alu_b};
         default: alu_y = 8'd0;
      endcase
   end

   // Expected response from the opcode rules, packed as {err, carry, zero, data}.
   function automatic logic [10:0] ref_rsp(input int op, input int a, input int b);
      int  r;
      bit  c;
      bit  e;
      r = 0; c = 0; e = 0;
      case (op)
         0: begin r = a + b;             c = (r > 15); end
         1: begin r = (a - b + 32) % 32; c = (a < b);  end
         2: r = a & b;
         3: r = a | b;
         4: r = 15 - a;
         5: r = 15 - (a & b);
         6: r = 15 - (a | b);
         7: r = a ^ b;
         8: r = 15 - (a ^ b);
         9: r = a * b;
         default: e = 1;
      endcase
      return {e, c, (r == 0), 8'(r)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a command and hold it until it is taken; returns at 1 time unit after the accepting edge.
   task automatic send_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, output bit ok);
      ok = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (cmd_ready) begin ok = 1; break; end
         @(posedge clk);
      end
      if (ok) step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output int lat);
      ok = 0; lat = 0;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) begin ok = 1; break; end
         step();
         lat++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      chk_cnt++;
      if ({cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err, op_count} !== '0) begin
         $display("FAIL reset_outputs: got rdy=%b a=%h b=%h ctrl=%h vld=%b data=%h z=%b c=%b e=%b cnt=%0d, need all zero",
                  cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err, op_count);
      end else pass_cnt++;
      step();
      rst = 1'b0;
      #1;
      chk_cnt++;
      if (cmd_ready !== 1'b1) $display("FAIL idle_ready: got %b need 1", cmd_ready);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      bit ok; int lat;
      rsp_ready = 1'b1;
      send_cmd(4'd0, 4'd9, 4'd8, ok);
      chk_cnt++;
      if (!ok || rsp_valid !== 1'b0 || {alu_ctrl, alu_a, alu_b} !== 12'h098)
         $display("FAIL add_exec: ok=%b vld=%b ctrl/a/b=%h need 1 0 098", ok, rsp_valid, {alu_ctrl, alu_a, alu_b});
      else pass_cnt++;
      wait_rsp(ok, lat);
      chk_cnt++;
      if (!ok || lat != 1 || rsp_data !== 8'h11 || rsp_carry !== 1'b1 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
         $display("FAIL add_rsp: ok=%b lat=%0d data=%h c=%b z=%b e=%b need lat 1 data 11 c1 z0 e0",
                  ok, lat, rsp_data, rsp_carry, rsp_zero, rsp_err);
      else pass_cnt++;
      send_cmd(4'd9, 4'd15, 4'd15, ok);
      wait_rsp(ok, lat);
      chk_cnt++;
      if (!ok || lat != 1 || rsp_data !== 8'hE1 || rsp_carry !== 1'b0 || rsp_err !== 1'b0)
         $display("FAIL mul_rsp: ok=%b lat=%0d data=%h c=%b e=%b need lat 1 data e1 c0 e0",
                  ok, lat, rsp_data, rsp_carry, rsp_err);
      else pass_cnt++;
      send_cmd(4'd2, 4'hA, 4'h5, ok);
      wait_rsp(ok, lat);
      chk_cnt++;
      if (!ok || rsp_data !== 8'h00 || rsp_zero !== 1'b1)
         $display("FAIL and_zero: ok=%b data=%h z=%b need data 00 z1", ok, rsp_data, rsp_zero);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (rsp_valid !== 1'b0 || op_count !== 8'd3)
         $display("FAIL count_after_3: vld=%b cnt=%0d need 0 3", rsp_valid, op_count);
      else pass_cnt++;
   endtask

   task automatic test_hold();
      bit ok; int lat;
      rsp_ready = 1'b0;
      send_cmd(4'd7, 4'd3, 4'd6, ok);
      wait_rsp(ok, lat);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (!ok || rsp_valid !== 1'b1 || rsp_data !== 8'h05 || cmd_ready !== 1'b0 || op_count !== 8'd3)
            $display("FAIL hold_stable[%0d]: ok=%b vld=%b data=%h rdy=%b cnt=%0d need 1 05 0 3",
                     i, ok, rsp_valid, rsp_data, cmd_ready, op_count);
         else pass_cnt++;
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk_cnt++;
      if (cmd_ready !== 1'b1) $display("FAIL drain_ready: got %b need 1", cmd_ready);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (rsp_valid !== 1'b0 || op_count !== 8'd4)
         $display("FAIL hold_release: vld=%b cnt=%0d need 0 4", rsp_valid, op_count);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit ok; int lat; int last;
      logic [10:0] exp;
      logic [3:0] op, a, b;
      do_reset();
      rsp_ready = 1'b1;
      last = 0;
      for (int i = 0; i < 4; i++) begin
         op = 4'($urandom_range(0, 9)); a = 4'($urandom); b = 4'($urandom);
         exp = ref_rsp(int'(op), int'(a), int'(b));
         send_cmd(op, a, b, ok);
         wait_rsp(ok, lat);
         chk_cnt++;
         if (!ok || {rsp_err, rsp_carry, rsp_zero, rsp_data} !== exp || (i > 0 && cyc - last != 2))
            $display("FAIL b2b[%0d]: op=%0d a=%0d b=%0d got %h gap=%0d need %h gap 2",
                     i, op, a, b, {rsp_err, rsp_carry, rsp_zero, rsp_data}, cyc - last, exp);
         else pass_cnt++;
         last = cyc;
      end
      step();
      chk_cnt++;
      if (op_count !== 8'd4) $display("FAIL b2b_count: got %0d need 4", op_count);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      bit ok; int lat;
      send_cmd(4'hC, 4'($urandom), 4'($urandom), ok);
      wait_rsp(ok, lat);
      chk_cnt++;
      if (!ok || rsp_err !== 1'b1 || rsp_data !== 8'h00 || rsp_zero !== 1'b1 || rsp_carry !== 1'b0 || alu_ctrl !== 4'hC)
         $display("FAIL illegal_op: ok=%b e=%b data=%h z=%b c=%b ctrl=%h need e1 00 z1 c0 ctrl c",
                  ok, rsp_err, rsp_data, rsp_zero, rsp_carry, alu_ctrl);
      else pass_cnt++;
      send_cmd(4'd1, 4'd5, 4'd3, ok);
      wait_rsp(ok, lat);
      chk_cnt++;
      if (!ok || rsp_data[3:0] !== 4'd2 || rsp_err !== 1'b0 || rsp_carry !== 1'b0)
         $display("FAIL sub_after_illegal: ok=%b data=%h e=%b c=%b need low 2 e0 c0", ok, rsp_data, rsp_err, rsp_carry);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (op_count !== 8'd6) $display("FAIL illegal_counted: got %0d need 6", op_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_exec();
      bit ok;
      bit seen;
      send_cmd(4'd9, 4'd15, 4'd15, ok);
      #2 rst = 1'b1;
      #1;
      chk_cnt++;
      if (!ok || {cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_err, op_count} !== '0)
         $display("FAIL reset_in_exec: ok=%b rdy=%b alu=%h vld=%b data=%h e=%b cnt=%0d need all zero",
                  ok, cmd_ready, {alu_ctrl, alu_a, alu_b}, rsp_valid, rsp_data, rsp_err, op_count);
      else pass_cnt++;
      step(); step();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid) seen = 1;
      end
      chk_cnt++;
      if (seen || op_count !== 8'd0)
         $display("FAIL no_rsp_after_reset: saw_valid=%b cnt=%0d need 0 0", seen, op_count);
      else pass_cnt++;
   endtask

   task automatic test_random();
      bit ok; int lat;
      logic [10:0] exp;
      logic [3:0] op, a, b;
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 260; i++) begin
         op = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
         exp = ref_rsp(int'(op), int'(a), int'(b));
         send_cmd(op, a, b, ok);
         wait_rsp(ok, lat);
         chk_cnt++;
         if (!ok || lat != 1 || {rsp_err, rsp_carry, rsp_zero, rsp_data} !== exp || op_count !== 8'(i % 256))
            $display("FAIL rand[%0d]: op=%0d a=%0d b=%0d got %h lat=%0d cnt=%0d need %h lat 1 cnt %0d",
                     i, op, a, b, {rsp_err, rsp_carry, rsp_zero, rsp_data}, lat, op_count, exp, i % 256);
         else pass_cnt++;
         if (!ok) break;
      end
      step();
      chk_cnt++;
      if (op_count !== 8'd4) $display("FAIL count_wrap: got %0d need 4", op_count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_illegal();
      test_reset_exec();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
